vad_decision_ctrl: RTL
======================

VAD_DECISION_CTRL -- requirements
Module: vad_decision_ctrl

Interface
REQ-001 SHALL have parameter HANG_LEN, default 8, giving the number of non-speech frames held as speech after the last speech frame (0 disables hangover).
REQ-002 SHALL have parameter CNT_W, default 4, giving the hangover counter width; HANG_LEN SHALL be at most 2^CNT_W-1.
REQ-003 SHALL have parameter ONSET_LEN, default 2, giving the consecutive speech frames needed to raise the flag (used only with VAD_ONSET_EN).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port layer_done, input, 1 bit: one-cycle pulse meaning the final-layer scores feeding the comparator are stable.
REQ-007 SHALL have port cmp_enable, output, 1 bit: drives the comparator enable.
REQ-008 SHALL have port cmp_result, input, 2 bits: registered comparator output; 10 = speech, 01 = non-speech, 00 = no result.
REQ-009 SHALL have port clr_err, input, 1 bit: one-cycle pulse that clears the sticky flags.
REQ-010 SHALL have port vad_valid, output, 1 bit: one-cycle pulse marking a new decision.
REQ-011 SHALL have port vad_flag, output, 1 bit: smoothed speech decision, held between decisions.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-013 SHALL have port ovf_err, output, 1 bit: sticky; set when a layer_done pulse is dropped.
REQ-014 SHALL have port res_err, output, 1 bit: sticky; set when cmp_result reads 00 in CAPT.

Function
REQ-015 SHALL implement the FSM IDLE -> EVAL -> CAPT -> IDLE; IDLE moves to EVAL only when layer_done=1, and EVAL and CAPT each last exactly one cycle.
REQ-016 SHALL drive cmp_enable=1 only in EVAL, so it is exactly one cycle per accepted frame.
REQ-017 SHALL sample cmp_result in CAPT, which is the cycle after EVAL and the first cycle in which the registered comparator output is valid.
REQ-018 SHALL assert vad_valid, with the updated vad_flag, in the cycle after CAPT: layer_done accepted in cycle t gives vad_valid in cycle t+3.
REQ-019 SHALL ignore layer_done while in EVAL or CAPT (including the CAPT-to-IDLE cycle), without changing the FSM, and SHALL set ovf_err in that case.
REQ-020 SHALL, on speech (10), load hang_cnt with HANG_LEN and set vad_flag=1, subject to REQ-031.
REQ-021 SHALL, on non-speech (01) with hang_cnt>0, decrement hang_cnt and keep vad_flag=1.
REQ-022 SHALL, on non-speech (01) with hang_cnt=0, clear vad_flag; hang_cnt SHALL saturate at 0 and never wrap.
REQ-023 SHALL treat 00 or 11 in CAPT as non-speech, set res_err, and still emit vad_valid.
REQ-024 SHALL, when HANG_LEN=0, make vad_flag follow the per-frame class directly.
REQ-025 SHALL, when clr_err and a new error occur in the same cycle, leave the flag set (set wins).
REQ-026 SHALL change vad_flag only in the cycle that vad_valid is asserted.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, drive state=IDLE, hang_cnt=0, onset_cnt=0, and outputs cmp_enable, vad_valid, vad_flag, busy, ovf_err and res_err to 0.
REQ-028 SHALL, on reset asserted mid-frame (EVAL or CAPT), abort the frame and suppress that frame's vad_valid.
REQ-029 SHALL ignore layer_done in a cycle where rst=1.

Configuration
REQ-030 SHALL gate onset debounce behind the macro VAD_ONSET_EN.
REQ-031 SHALL, with VAD_ONSET_EN defined, raise vad_flag from 0 only after ONSET_LEN consecutive speech frames; onset_cnt SHALL saturate at ONSET_LEN, reset to 0 on any non-speech frame, and not apply while vad_flag=1.
REQ-032 SHALL, with VAD_ONSET_EN undefined, raise the flag on a single speech frame and contain no onset counter logic.

Structure
REQ-033 SHALL take the FSM state type and the class codes (CLS_SPEECH=2'b10, CLS_NONSPEECH=2'b01, CLS_NONE=2'b00) from shared package vad_pkg.
REQ-034 SHALL place the hangover and onset logic in one sub-module, vad_hangover (inputs: update strobe, is_speech; output: flag), with the FSM kept in vad_decision_ctrl.

Verification
REQ-035 SHALL check basic flow: layer_done at t with cmp_result=10 in CAPT -> cmp_enable high only at t+1, vad_valid and vad_flag=1 at t+3, busy high t+1..t+2.
REQ-036 SHALL check hangover with HANG_LEN=3: speech, then 5 non-speech frames -> vad_flag = 1,1,1,1,0,0.
REQ-037 SHALL check overflow: layer_done at t and again at t+1 and t+2 -> only one vad_valid, ovf_err=1 from t+2; clr_err pulse -> ovf_err=0.
REQ-038 SHALL check bad result: cmp_result=00 in CAPT -> vad_valid=1, vad_flag=0 (hang_cnt=0), res_err=1.
REQ-039 SHALL check reset mid-frame: rst=1 in the CAPT cycle -> no vad_valid, all outputs 0 next cycle, and the next layer_done is processed normally.
REQ-040 SHALL check onset with VAD_ONSET_EN and ONSET_LEN=2: frames speech, non-speech, speech, speech -> vad_flag = 0,0,0,1.

Source files
------------

// File: rtl/vad_pkg.sv
// Shared types and comparator class codes for the VAD decision controller.
package vad_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StEval = 2'b01,
    StCapt = 2'b10
  } state_e;

  localparam logic [1:0] CLS_SPEECH    = 2'b10;
  localparam logic [1:0] CLS_NONSPEECH = 2'b01;
  localparam logic [1:0] CLS_NONE      = 2'b00;

endpackage

// File: rtl/vad_hangover.sv
// Hangover smoothing of per-frame speech decisions, with optional onset debounce
// enabled by defining VAD_ONSET_EN.
module vad_hangover #(
  parameter int unsigned HANG_LEN  = 8,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned ONSET_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic update,
  input  logic is_speech,
  output logic flag
);

  if (HANG_LEN > (2 ** CNT_W) - 1) begin : g_bad_hang
    $error("HANG_LEN does not fit in CNT_W bits");
  end
  if (ONSET_LEN == 0) begin : g_bad_onset
    $error("ONSET_LEN must be at least 1");
  end

  logic [CNT_W-1:0] hang_cnt_q;
  logic             flag_q;
  logic             onset_met;

`ifdef VAD_ONSET_EN
  localparam int unsigned OnsetW = $clog2(ONSET_LEN + 1);

  logic [OnsetW-1:0] onset_cnt_q;

  // The current frame completes the run when the count already holds ONSET_LEN-1.
  assign onset_met = flag_q || (onset_cnt_q >= OnsetW'(ONSET_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      onset_cnt_q <= '0;
    end else if (update) begin
      if (!is_speech) begin
        onset_cnt_q <= '0;
      end else if (!flag_q && (onset_cnt_q < OnsetW'(ONSET_LEN))) begin
        onset_cnt_q <= onset_cnt_q + 1'b1;
      end
    end
  end
`else
  assign onset_met = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hang_cnt_q <= '0;
      flag_q     <= 1'b0;
    end else if (update) begin
      if (is_speech) begin
        if (onset_met) begin
          flag_q     <= 1'b1;
          hang_cnt_q <= CNT_W'(HANG_LEN);
        end
      end else if (hang_cnt_q != '0) begin
        hang_cnt_q <= hang_cnt_q - 1'b1;
      end else begin
        flag_q <= 1'b0;
      end
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/vad_decision_ctrl.sv
// Sequences the comparator per frame and emits a smoothed speech decision.
// Onset debounce is built only when VAD_ONSET_EN is defined.
module vad_decision_ctrl
  import vad_pkg::*;
#(
  parameter int unsigned HANG_LEN  = 8,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned ONSET_LEN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       layer_done,
  output logic       cmp_enable,
  input  logic [1:0] cmp_result,
  input  logic       clr_err,
  output logic       vad_valid,
  output logic       vad_flag,
  output logic       busy,
  output logic       ovf_err,
  output logic       res_err
);

  state_e state_q;
  logic   cmp_enable_q;
  logic   vad_valid_q;
  logic   busy_q;
  logic   ovf_err_q;
  logic   res_err_q;

  logic capt_update;
  logic is_speech;
  logic bad_result;

  assign capt_update = (state_q == StCapt) && !rst;
  assign is_speech   = (cmp_result == CLS_SPEECH);
  assign bad_result  = (cmp_result != CLS_SPEECH) && (cmp_result != CLS_NONSPEECH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cmp_enable_q <= 1'b0;
      vad_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      ovf_err_q    <= 1'b0;
      res_err_q    <= 1'b0;
    end else begin
      cmp_enable_q <= 1'b0;
      vad_valid_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (layer_done) begin
            state_q      <= StEval;
            cmp_enable_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        StEval: begin
          state_q <= StCapt;
        end
        StCapt: begin
          state_q     <= StIdle;
          busy_q      <= 1'b0;
          vad_valid_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase

      // A new error in the same cycle as clr_err keeps the flag set.
      if (layer_done && (state_q != StIdle)) begin
        ovf_err_q <= 1'b1;
      end else if (clr_err) begin
        ovf_err_q <= 1'b0;
      end

      if ((state_q == StCapt) && bad_result) begin
        res_err_q <= 1'b1;
      end else if (clr_err) begin
        res_err_q <= 1'b0;
      end
    end
  end

  vad_hangover #(
    .HANG_LEN  (HANG_LEN),
    .CNT_W     (CNT_W),
    .ONSET_LEN (ONSET_LEN)
  ) u_hangover (
    .clk       (clk),
    .rst       (rst),
    .update    (capt_update),
    .is_speech (is_speech),
    .flag      (vad_flag)
  );

  assign cmp_enable = cmp_enable_q;
  assign vad_valid  = vad_valid_q;
  assign busy       = busy_q;
  assign ovf_err    = ovf_err_q;
  assign res_err    = res_err_q;

endmodule
